// File: rtl/piso_tx_if.sv
// Purpose : Word handshake between a parallel sender and the piso_tx
//           serialiser. The sender presents i_data with i_valid and holds both
//           until the transmitter shows o_ready at a rising edge.
// Signals :
//   i_data   DWIDTH  parallel word, sender -> transmitter
//   i_valid  1       i_data is valid, sender -> transmitter
//   o_ready  1       transmitter idle and able to accept, transmitter -> sender
// Modports: master = word sender, slave = piso_tx.
interface piso_tx_if #(
   parameter int DWIDTH = 8
) ();

   logic [DWIDTH-1:0] i_data;
   logic              i_valid;
   logic              o_ready;

   modport master (
      output i_data,
      output i_valid,
      input  o_ready
   );

   modport slave (
      input  i_data,
      input  i_valid,
      output o_ready
   );

endinterface

// File: rtl/piso_tx.sv
// Purpose : Parallel-in/serial-out transmitter. A DWIDTH-bit word is accepted
//           over the valid/ready handshake in bus, then shifted out one bit per
//           clock on o_sdata with o_sframe marking the frame bits. Every
//           output is driven from a flop, so there is no combinational path
//           from any input to any output.
// Parameters:
//   DWIDTH     word width in bits (>= 1)
//   MSB_FIRST  1: bit DWIDTH-1 is sent first, 0: bit 0 is sent first
// Ports:
//   i_clk     rising-edge clock
//   i_rstn    asynchronous active-low reset
//   bus       slave side of piso_tx_if (i_data, i_valid in; o_ready out)
//   o_sdata   serial data bit
//   o_sframe  high while o_sdata carries a frame bit
//   o_done    one-cycle pulse on the final frame bit
// Build option:
//   PISO_TX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      and o_done moves onto that parity bit.
module piso_tx #(
   parameter int DWIDTH    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic     i_clk,
   input  logic     i_rstn,
   piso_tx_if.slave bus,
   output logic     o_sdata,
   output logic     o_sframe,
   output logic     o_done
);

   // The counter only needs to reach DWIDTH-1, but sizing it for DWIDTH
   // keeps it from ever wrapping inside a frame, including DWIDTH=1.
   localparam int            CW       = $clog2(DWIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DWIDTH - 1);

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     bit_cnt_next;
   logic [DWIDTH-1:0] shift_reg;
   logic [DWIDTH-1:0] shift_reg_next;
   logic [DWIDTH-1:0] shifted;
   logic              ready_reg;
   logic              ready_next;
   logic              sdata_next;
   logic              sframe_next;
   logic              done_next;
`ifdef PISO_TX_PARITY_EN
   logic              parity_reg;
   logic              parity_next;
`endif

   // The bit that goes on the line first for a given shift register image.
   function automatic logic first_bit(input logic [DWIDTH-1:0] word);
      return MSB_FIRST ? word[DWIDTH-1] : word[0];
   endfunction

   assign bus.o_ready = ready_reg;

   // State, counter, data and all outputs are registered together here; the
   // combinational block below decides what each of them becomes next.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         ready_reg  <= 1'b1;
         o_sdata    <= 1'b0;
         o_sframe   <= 1'b0;
         o_done     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         bit_cnt    <= bit_cnt_next;
         shift_reg  <= shift_reg_next;
         ready_reg  <= ready_next;
         o_sdata    <= sdata_next;
         o_sframe   <= sframe_next;
         o_done     <= done_next;
`ifdef PISO_TX_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   // Next-state and next-output logic. Outputs are computed one cycle ahead
   // so that the registered value lines up with the bit being transmitted:
   // the accept edge already presents the first bit, and o_done is set on the
   // edge that makes the final bit visible.
   always_comb begin
      state_next     = state;
      bit_cnt_next   = bit_cnt;
      shift_reg_next = shift_reg;
      ready_next     = ready_reg;
      sdata_next     = o_sdata;
      sframe_next    = o_sframe;
      done_next      = 1'b0;
      shifted        = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
`ifdef PISO_TX_PARITY_EN
      parity_next    = parity_reg;
`endif

      case (state)
         IDLE: begin
            ready_next  = 1'b1;
            sframe_next = 1'b0;
            sdata_next  = 1'b0;
            if (bus.i_valid) begin
               state_next     = SHIFT;
               bit_cnt_next   = '0;
               shift_reg_next = bus.i_data;
               ready_next     = 1'b0;
               sframe_next    = 1'b1;
               sdata_next     = first_bit(bus.i_data);
`ifdef PISO_TX_PARITY_EN
               parity_next    = ^bus.i_data;
`else
               // A one-bit word is complete in its first cycle.
               done_next      = (LAST_CNT == '0);
`endif
            end
         end

         SHIFT: begin
            if (bit_cnt == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
               state_next  = PARITY;
               ready_next  = 1'b0;
               sframe_next = 1'b1;
               sdata_next  = parity_reg;
               done_next   = 1'b1;
`else
               state_next  = IDLE;
               ready_next  = 1'b1;
               sframe_next = 1'b0;
               sdata_next  = 1'b0;
`endif
            end else begin
               bit_cnt_next   = bit_cnt + CW'(1);
               shift_reg_next = shifted;
               sdata_next     = first_bit(shifted);
`ifndef PISO_TX_PARITY_EN
               done_next      = ((bit_cnt + CW'(1)) == LAST_CNT);
`endif
            end
         end

`ifdef PISO_TX_PARITY_EN
         PARITY: begin
            state_next  = IDLE;
            ready_next  = 1'b1;
            sframe_next = 1'b0;
            sdata_next  = 1'b0;
         end
`endif

         default: begin
            state_next  = IDLE;
            ready_next  = 1'b1;
            sframe_next = 1'b0;
            sdata_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_tx.sv
// Purpose : Self-checking bench for piso_tx. Three instances are exercised:
//           an 8-bit MSB-first transmitter, an 8-bit LSB-first transmitter and
//           a 1-bit transmitter. Expected serial sequences are hand-derived
//           constants; the parity bit is appended when PISO_TX_PARITY_EN is
//           defined for the build.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic i_clk;
   logic i_rstn;

   logic sdata_a, sframe_a, done_a;
   logic sdata_b, sframe_b, done_b;
   logic sdata_c, sframe_c, done_c;

   int checks   = 0;
   int failures = 0;

   piso_tx_if #(.DWIDTH(8)) if_a ();
   piso_tx_if #(.DWIDTH(8)) if_b ();
   piso_tx_if #(.DWIDTH(1)) if_c ();

   piso_tx #(.DWIDTH(8), .MSB_FIRST(1'b1)) dut_a (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .bus     (if_a),
      .o_sdata (sdata_a),
      .o_sframe(sframe_a),
      .o_done  (done_a)
   );

   piso_tx #(.DWIDTH(8), .MSB_FIRST(1'b0)) dut_b (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .bus     (if_b),
      .o_sdata (sdata_b),
      .o_sframe(sframe_b),
      .o_done  (done_b)
   );

   piso_tx #(.DWIDTH(1), .MSB_FIRST(1'b1)) dut_c (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .bus     (if_c),
      .o_sdata (sdata_c),
      .o_sframe(sframe_c),
      .o_done  (done_c)
   );

   // Observed output bundle per instance: {ready, sdata, sframe, done}.
   logic [3:0] obs_a, obs_b, obs_c;
   assign obs_a = {if_a.o_ready, sdata_a, sframe_a, done_a};
   assign obs_b = {if_b.o_ready, sdata_b, sframe_b, done_b};
   assign obs_c = {if_c.o_ready, sdata_c, sframe_c, done_c};

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] pick(input int sel);
      case (sel)
         0:       return obs_a;
         1:       return obs_b;
         default: return obs_c;
      endcase
   endfunction

   task automatic drive(input int sel, input logic valid, input logic [7:0] data);
      case (sel)
         0: begin if_a.i_valid = valid; if_a.i_data = data; end
         1: begin if_b.i_valid = valid; if_b.i_data = data; end
         default: begin if_c.i_valid = valid; if_c.i_data = data[0]; end
      endcase
   endtask

   // Present a word, let one rising edge accept it, then drop i_valid.
   // Leaves the bench 1 time unit after the accept edge.
   task automatic start_word(input int sel, input logic [7:0] data);
      drive(sel, 1'b1, data);
      @(posedge i_clk);
      #1;
      drive(sel, 1'b0, data);
   endtask

   // Records one frame starting at the current sample point: bits[i] is the
   // i-th bit on the line. Optionally raises i_valid with inj_data at frame
   // cycle inj_at and holds it. Bounded to 20 cycles.
   task automatic capture(input int sel, input int inj_at, input logic [7:0] inj_data,
                          output logic [31:0] bits, output int len,
                          output int done_pos, output int done_cnt,
                          output logic ready_in, output logic ready_after);
      logic [3:0] o;
      bits     = '0;
      len      = 0;
      done_pos = -1;
      done_cnt = 0;
      ready_in = 1'b0;
      o        = pick(sel);
      while (o[1] && len < 20) begin
         bits[len] = o[2];
         if (o[0]) begin
            done_pos = len;
            done_cnt++;
         end
         if (o[3]) ready_in = 1'b1;
         if (len == inj_at) drive(sel, 1'b1, inj_data);
         len++;
         @(posedge i_clk);
         #1;
         o = pick(sel);
      end
      if (o[0]) done_cnt++;
      ready_after = o[3];
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (obs_a !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_a: got %b expected 1000", obs_a);
      end
      checks++;
      if (obs_b !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_b: got %b expected 1000", obs_b);
      end
      checks++;
      if (obs_c !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_c: got %b expected 1000", obs_c);
      end
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      checks++;
      if (obs_a !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL idle_after_reset: got %b expected 1000", obs_a);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0]  words [2] = '{8'hA5, 8'h07};
      logic [31:0] exp_b [2] = '{32'h0A5, 32'h0E0 | (PAR ? 32'h100 : 32'h0)};
      logic [31:0] bits;
      int len, dpos, dcnt;
      logic rin, raft;
      for (int i = 0; i < 2; i++) begin
         start_word(0, words[i]);
         capture(0, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
         checks++;
         if (bits !== exp_b[i]) begin
            failures++;
            $display("[TB] FAIL msb_bits_%h: got %h expected %h", words[i], bits, exp_b[i]);
         end
         checks++;
         if (len != 8 + PAR || dpos != 7 + PAR || dcnt != 1) begin
            failures++;
            $display("[TB] FAIL msb_frame_%h: got len %0d done@%0d x%0d expected len %0d done@%0d x1",
                     words[i], len, dpos, dcnt, 8 + PAR, 7 + PAR);
         end
         checks++;
         if (rin !== 1'b0 || raft !== 1'b1) begin
            failures++;
            $display("[TB] FAIL msb_ready_%h: got in-frame %b after %b expected 0 1", words[i], rin, raft);
         end
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0]  words [2] = '{8'h01, 8'h06};
      logic [31:0] exp_b [2] = '{32'h001 | (PAR ? 32'h100 : 32'h0), 32'h006};
      logic [31:0] bits;
      int len, dpos, dcnt;
      logic rin, raft;
      for (int i = 0; i < 2; i++) begin
         start_word(1, words[i]);
         capture(1, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
         checks++;
         if (bits !== exp_b[i]) begin
            failures++;
            $display("[TB] FAIL lsb_bits_%h: got %h expected %h", words[i], bits, exp_b[i]);
         end
         checks++;
         if (len != 8 + PAR || dpos != 7 + PAR || dcnt != 1 || raft !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lsb_frame_%h: got len %0d done@%0d x%0d ready %b expected len %0d done@%0d x1 ready 1",
                     words[i], len, dpos, dcnt, raft, 8 + PAR, 7 + PAR);
         end
      end
   endtask

   task automatic test_width_one();
      logic [31:0] bits;
      logic [31:0] exp_bits;
      int len, dpos, dcnt;
      logic rin, raft;
      for (int w = 0; w < 2; w++) begin
         start_word(2, 8'(w));
         capture(2, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
         exp_bits = (w == 1) ? (PAR ? 32'h3 : 32'h1) : 32'h0;
         checks++;
         if (bits !== exp_bits || len != 1 + PAR) begin
            failures++;
            $display("[TB] FAIL w1_frame_%0d: got bits %h len %0d expected %h len %0d",
                     w, bits, len, exp_bits, 1 + PAR);
         end
         checks++;
         if (dpos != PAR || dcnt != 1 || raft !== 1'b1) begin
            failures++;
            $display("[TB] FAIL w1_done_%0d: got done@%0d x%0d ready %b expected done@%0d x1 ready 1",
                     w, dpos, dcnt, raft, PAR);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] bits;
      int len, dpos, dcnt;
      logic rin, raft;
      start_word(0, 8'hFF);
      capture(0, 2, 8'h3C, bits, len, dpos, dcnt, rin, raft);
      checks++;
      if (bits !== (PAR ? 32'h0FF : 32'h0FF) || len != 8 + PAR || rin !== 1'b0) begin
         failures++;
         $display("[TB] FAIL busy_ff_frame: got bits %h len %0d ready-in-frame %b expected 0ff len %0d 0",
                  bits, len, rin, 8 + PAR);
      end
      checks++;
      if (raft !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_gap_ready: got %b expected 1", raft);
      end
      @(posedge i_clk);
      #1;
      drive(0, 1'b0, 8'h3C);
      capture(0, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
      checks++;
      if (bits !== 32'h03C || len != 8 + PAR || dcnt != 1) begin
         failures++;
         $display("[TB] FAIL busy_3c_frame: got bits %h len %0d done x%0d expected 03c len %0d x1",
                  bits, len, dcnt, 8 + PAR);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] bits;
      int len, dpos, dcnt;
      logic rin, raft;
      drive(0, 1'b1, 8'hFF);
      @(posedge i_clk);
      #1;
      capture(0, 0, 8'h00, bits, len, dpos, dcnt, rin, raft);
      checks++;
      if (bits !== 32'h0FF || len != 8 + PAR || raft !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_first: got bits %h len %0d ready %b expected 0ff len %0d ready 1",
                  bits, len, raft, 8 + PAR);
      end
      @(posedge i_clk);
      #1;
      capture(0, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
      drive(0, 1'b0, 8'h00);
      checks++;
      if (bits !== 32'h000 || len != 8 + PAR || dpos != 7 + PAR) begin
         failures++;
         $display("[TB] FAIL b2b_second: got bits %h len %0d done@%0d expected 000 len %0d done@%0d",
                  bits, len, dpos, 8 + PAR, 7 + PAR);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (obs_a !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL b2b_idle: got %b expected 1000", obs_a);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] bits;
      int len, dpos, dcnt;
      logic rin, raft;
      int early_done = 0;
      start_word(0, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         if (done_a) early_done++;
         @(posedge i_clk);
         #1;
      end
      i_rstn = 1'b0;
      #1;
      checks++;
      if (obs_a !== 4'b1000 || early_done != 0) begin
         failures++;
         $display("[TB] FAIL midframe_reset: got %b early done %0d expected 1000 0", obs_a, early_done);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (obs_a !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_hold: got %b expected 1000", obs_a);
      end
      i_rstn = 1'b1;
      start_word(0, 8'h81);
      capture(0, -1, 8'h00, bits, len, dpos, dcnt, rin, raft);
      checks++;
      if (bits !== 32'h081 || len != 8 + PAR || dpos != 7 + PAR || dcnt != 1 || raft !== 1'b1) begin
         failures++;
         $display("[TB] FAIL post_reset_frame: got bits %h len %0d done@%0d x%0d ready %b expected 081 len %0d done@%0d x1 ready 1",
                  bits, len, dpos, dcnt, raft, 8 + PAR, 7 + PAR);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_width_one();
      test_busy_ignore();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
